// File: rtl/mux_rr_arbiter.sv
// Four-way round-robin arbiter: muxes one requester onto y_out for bursts of up to
// MAX_BURST beats, with a mandatory IDLE cycle between grants.
module mux_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req1,
  input  logic             req2,
  input  logic             req3,
  input  logic             req4,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  output logic             ack1,
  output logic             ack2,
  output logic             ack3,
  output logic             ack4,
  output logic [WIDTH-1:0] y_out,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel0,
  output logic             sel1,
  output logic             busy
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [1:0]      sel;
  logic [1:0]      last_grant;
  logic [CW-1:0]   beat_cnt;
  logic [3:0]      req;
  logic [1:0]      winner;
  logic [1:0]      idx;
  logic            granted_req;
  logic            xfer;
  logic [3:0]      ack;

  assign req = {req4, req3, req2, req1};

  // Scan downward so the candidate closest after last_grant is the last to overwrite.
  always_comb begin
    winner = last_grant;
    idx    = last_grant;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant + k[1:0];
      if (req[idx]) winner = idx;
    end
  end

  assign granted_req = req[sel];
  // A beat offered while reset is sampled must never be acknowledged.
  assign y_valid     = (state == GRANT) && granted_req && !rst;
  assign xfer        = y_valid && y_ready;
  assign ack         = xfer ? (4'b0001 << sel) : 4'b0000;
  assign {ack4, ack3, ack2, ack1} = ack;
  assign busy        = (state == GRANT);
  assign sel0        = sel[0];
  assign sel1        = sel[1];

  always_comb begin
    y_out = '0;
    if (state == GRANT) begin
      case (sel)
        2'd0:    y_out = i1;
        2'd1:    y_out = i2;
        2'd2:    y_out = i3;
        default: y_out = i4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 2'b00;
      last_grant <= 2'b11;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state      <= GRANT;
            sel        <= winner;
            last_grant <= winner;
            beat_cnt   <= '0;
          end
        end
        default: begin
          if (!granted_req) begin
            state <= IDLE;
          end else if (xfer) begin
            if (beat_cnt == CW'(MAX_BURST - 1)) state <= IDLE;
            else beat_cnt <= beat_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed vector table, corner-case sequences and
// randomized traffic against a cycle-level round-robin reference model.
module tb_mux_rr_arbiter;

  localparam int W  = 8;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] din [4];
  logic         ready;
  wire  [3:0]   ack;
  wire  [W-1:0] y_out;
  wire          y_valid, sel0, sel1, busy;
  wire  [15:0]  dut_out;

  assign dut_out = {busy, sel1, sel0, y_valid, ack, y_out};

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req1(req[0]), .req2(req[1]), .req3(req[2]), .req4(req[3]),
    .i1(din[0]), .i2(din[1]), .i3(din[2]), .i4(din[3]),
    .ack1(ack[0]), .ack2(ack[1]), .ack3(ack[2]), .ack4(ack[3]),
    .y_out(y_out), .y_valid(y_valid), .y_ready(ready),
    .sel0(sel0), .sel1(sel1), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] last_out;

  // Reference model: grant is -1 when idle, otherwise the requester index.
  int m_grant, m_last, m_beats, m_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_out();
    logic       v;
    logic [3:0] a;
    logic [7:0] y;
    v = (m_grant >= 0) && req[m_grant] && !rst;
    a = (v && ready) ? (4'b0001 << m_grant) : 4'b0000;
    y = (m_grant >= 0) ? din[m_grant] : 8'h00;
    return {(m_grant >= 0), m_sel[1:0], v, a, y};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_grant = -1; m_sel = 0; m_last = 3; m_beats = 0;
    end else if (m_grant < 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (req[(m_last + k) % 4]) begin
          m_grant = (m_last + k) % 4;
          m_sel = m_grant; m_last = m_grant; m_beats = 0;
          break;
        end
      end
    end else if (!req[m_grant]) begin
      m_grant = -1;
    end else if (ready) begin
      m_beats++;
      if (m_beats == MB) m_grant = -1;
    end
  endtask

  task automatic cyc(input string name);
    @(negedge clk);
    last_out = dut_out;
    check(name, dut_out, model_out());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; ready = 1'b1;
    cyc("reset_idle");
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        rdy;
    logic [15:0] exp; // {busy, sel[1:0], valid, ack[3:0], y_out}
  } vec_t;

  vec_t vecs [10];

  initial begin
    int cnt;
    int order [$];
    logic prev_busy;

    din[0] = 8'h11; din[1] = 8'hA5; din[2] = 8'h33; din[3] = 8'h44;
    rst = 1'b1; req = 4'b0000; ready = 1'b1;
    @(posedge clk); model_step(); #1;
    do_reset();

    // Single requester bursts, one IDLE gap, then last_grant=01 with req1+req3.
    vecs[0] = '{1'b0, 4'b0010, 1'b1, 16'h0000};
    vecs[1] = '{1'b0, 4'b0010, 1'b1, 16'hB2A5};
    vecs[2] = '{1'b0, 4'b0010, 1'b1, 16'hB2A5};
    vecs[3] = '{1'b0, 4'b0010, 1'b1, 16'hB2A5};
    vecs[4] = '{1'b0, 4'b0010, 1'b1, 16'hB2A5};
    vecs[5] = '{1'b0, 4'b0010, 1'b1, 16'h2000};
    vecs[6] = '{1'b0, 4'b0010, 1'b1, 16'hB2A5};
    vecs[7] = '{1'b0, 4'b0000, 1'b1, 16'hA0A5};
    vecs[8] = '{1'b0, 4'b0101, 1'b1, 16'h2000};
    vecs[9] = '{1'b0, 4'b0101, 1'b1, 16'hD433};
    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst; req = vecs[i].req; ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d", i), dut_out, vecs[i].exp);
      @(posedge clk); model_step(); #1;
    end

    // All four requesting: grant order 1,2,3,4,1.
    do_reset();
    req = 4'b1111; prev_busy = 1'b0;
    for (int i = 0; i < 27; i++) begin
      cyc("rr_all");
      if (busy && !prev_busy) order.push_back({sel1, sel0});
      prev_busy = busy;
    end
    check("rr_count", (order.size() >= 5), 1);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check($sformatf("rr_order%0d", i), order[i], (i % 4));

    // Backpressure on a grant to i3.
    do_reset();
    req = 4'b0100;
    cyc("bp_idle");
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc("bp_stall");
      check("bp_valid_noack", {last_out[12], last_out[10]}, 2'b10);
    end
    ready = 1'b1; cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc("bp_drain");
      if (last_out[10]) cnt++;
    end
    check("bp_beats", cnt, 4);
    check("bp_gap_idle", last_out[15], 1'b0);

    // Early drop of req1 after two beats, req4 waiting.
    do_reset();
    req = 4'b1001;
    cyc("drop_idle");
    cyc("drop_b1");
    cyc("drop_b2");
    req = 4'b1000;
    cyc("drop_nobeat");
    cyc("drop_gap");
    check("drop_gap_idle", last_out[15], 1'b0);
    cyc("drop_next");
    check("drop_sel4", {last_out[15], last_out[14:13]}, 3'b111);

    // Reset during beat 2 of a grant to i3.
    do_reset();
    req = 4'b0100;
    cyc("rm_idle");
    cyc("rm_b1");
    rst = 1'b1;
    cyc("rm_rst");
    check("rm_no_ack", last_out[12:8], 5'b0);
    rst = 1'b0; req = 4'b0101;
    cyc("rm_after");
    check("rm_idle_vals", last_out[15:12], 4'b0000);
    cyc("rm_grant");
    check("rm_sel1", {last_out[15], last_out[14:13]}, 3'b100);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (!req[k]) din[k] = 8'($urandom);
        if (req[k] && $urandom_range(7) == 0) req[k] = 1'b0;
        else if (!req[k] && $urandom_range(2) == 0) req[k] = 1'b1;
      end
      ready = ($urandom_range(3) != 0);
      rst = ($urandom_range(199) == 0);
      cyc("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, is the data width of every input channel and of y_out.
REQ-002 Parameter MAX_BURST, default 4, is the maximum number of beats one grant may transfer; legal range is 1..16.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  is a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req1..req4  input  1 each  are per-requester requests; while a request is high, that requester SHALL hold its data stable.
REQ-006 i1..i4  input  WIDTH each  are the per-requester data channels.
REQ-007 ack1..ack4  output  1 each  pulse high for one beat accepted from that requester.
REQ-008 y_out  output  WIDTH  carries the data of the muxed, granted channel.
REQ-009 y_valid  output  1  indicates that y_out holds a valid beat.
REQ-010 y_ready  input  1  is downstream acceptance; a beat transfers in any cycle where y_valid && y_ready.
REQ-011 sel0, sel1  output  1 each  form the grant index {sel1,sel0}: 00 selects i1, 01 selects i2, 10 selects i3, 11 selects i4.
REQ-012 busy  output  1  is high while in state GRANT.

Function
REQ-013 The block SHALL have two states: IDLE and GRANT.
REQ-014 It SHALL hold the internal registers last_grant (2 bits) and beat_cnt (width ceil(log2(MAX_BURST))+1).
REQ-015 In IDLE with at least one reqN high at a clock edge, the block SHALL enter GRANT and load {sel1,sel0} with the winner.
  - The winner is the first asserted request searching from index last_grant+1 upward, modulo 4.
  - last_grant SHALL be set to the winner.
  - beat_cnt SHALL be set to 0.
REQ-016 In IDLE with no request, the block SHALL stay in IDLE and leave sel and last_grant unchanged.
REQ-017 Latency: a request asserted in an IDLE cycle N SHALL produce y_valid no earlier than cycle N+1.
REQ-018 In IDLE, y_out SHALL be 0, y_valid 0, all ackN 0, and busy 0.
REQ-019 In GRANT, y_out SHALL equal the selected input combinationally, and y_valid SHALL equal the granted reqN.
REQ-020 In GRANT, ackN SHALL equal y_valid && y_ready for the granted N only, and 0 for all other requesters.
REQ-021 A transfer with beat_cnt == MAX_BURST-1 SHALL return the block to IDLE at that edge.
REQ-022 Any other transfer SHALL increment beat_cnt.
REQ-023 If the granted reqN is low at a clock edge in GRANT, the block SHALL return to IDLE with no transfer.
REQ-024 Requests from non-granted requesters SHALL be ignored during GRANT; there is no preemption.
REQ-025 Every return to IDLE SHALL insert exactly one IDLE cycle before the next grant.
REQ-026 With y_ready held low, the block SHALL hold the grant indefinitely; y_out and sel SHALL stay stable and beat_cnt SHALL not change.
REQ-027 If several requests are high simultaneously, the round-robin order alone SHALL decide the winner; no requester waits more than 3 grants.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL take these values, overriding all other activity, including mid-burst:
  - state = IDLE
  - {sel1,sel0} = 00
  - last_grant = 11
  - beat_cnt = 0
REQ-029 During and after reset, outputs SHALL take their IDLE values (REQ-018) from the first edge with rst high.
REQ-030 After reset, i1 SHALL have highest priority, because last_grant = 11.
REQ-031 A beat presented in the cycle that rst is sampled high SHALL NOT be acknowledged.

Verification
REQ-032 Single requester with burst (MAX_BURST=4, y_ready=1): release rst, hold req2=1 and i2=8'hA5.
  - Response: sel=01 from cycle 1.
  - Response: y_out=8'hA5 and ack2=1 for 4 cycles.
  - Response: one IDLE cycle, then a new 4-beat grant to i2.
REQ-033 All four requesting (y_ready=1): req1..req4 all held high.
  - Response: grants in the order i1, i2, i3, i4, i1.
  - Response: each grant lasts 4 beats and is separated by one IDLE cycle.
REQ-034 Backpressure: grant to i3, then y_ready=0 for 5 cycles, then y_ready=1.
  - Response: y_valid=1 and ack3=0 for 5 cycles.
  - Response: beat_cnt is unchanged during the stall.
  - Response: 4 beats follow once y_ready returns high.
REQ-035 Early drop: drop req1 after 2 accepted beats while req4 is high.
  - Response: IDLE on the next edge.
  - Response: then a grant to i4 with sel=11.
REQ-036 Reset mid-burst: assert rst during beat 2 of a grant to i3.
  - Response: on the next edge busy=0, y_valid=0, sel=00.
  - Response: after reset, with req1 and req3 both high, i1 is granted first.
REQ-037 Simultaneous release and new request (last_grant=01): req1 and req3 asserted together in IDLE.
  - Response: i3 is granted (search order 10, 11, 00).
